// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, one-entry skid buffer and IF/ID latch.
// Optional IFETCH_PERF_EN adds fetch_count/stall_count performance counters.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        pcen,
  input  logic        if_id_en,
  input  logic        if_id_flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_npc,
  output logic        id_valid,
  output logic        fetch_halted
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_HOLD   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic            valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '0;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_skid;
  logic [XLEN-1:0] w_skid_nxt;
  ifid_t           r_ifid;
  ifid_t           w_ifid_nxt;
  logic            w_advance;
  logic [XLEN-1:0] w_pc_plus4;

  assign w_advance  = pcen && if_id_en;
  assign w_pc_plus4 = r_pc + PC_STEP;

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_FETCH;
      r_pc    <= PC_INIT;
      r_skid  <= '0;
      r_ifid  <= IFID_BUBBLE;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_skid  <= w_skid_nxt;
      r_ifid  <= w_ifid_nxt;
    end
  end

  // Next-state: halt > redirect > flush > normal advance/stall
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_skid_nxt  = r_skid;
    w_ifid_nxt  = r_ifid;

    if (r_state == S_HALTED) begin
      if (if_id_flush) w_ifid_nxt = IFID_BUBBLE;
    end else if (halt) begin
      w_state_nxt = S_HALTED;
      w_skid_nxt  = '0;
      w_ifid_nxt  = IFID_BUBBLE;
    end else if (redirect_valid) begin
      w_state_nxt = S_FETCH;
      w_pc_nxt    = redirect_pc & ALIGN_MASK;
      w_skid_nxt  = '0;
      w_ifid_nxt  = IFID_BUBBLE;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (ihit && w_advance) begin
            w_pc_nxt   = w_pc_plus4;
            w_ifid_nxt = '{instr: imemload, pc: r_pc, npc: w_pc_plus4, valid: 1'b1};
          end else if (ihit) begin
            // Word returned but downstream stalled: park it until released
            w_skid_nxt  = imemload;
            w_state_nxt = S_HOLD;
          end else if (if_id_en) begin
            w_ifid_nxt = IFID_BUBBLE;
          end
        end
        S_HOLD: begin
          if (w_advance) begin
            w_pc_nxt    = w_pc_plus4;
            w_skid_nxt  = '0;
            w_ifid_nxt  = '{instr: r_skid, pc: r_pc, npc: w_pc_plus4, valid: 1'b1};
            w_state_nxt = S_FETCH;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
      if (if_id_flush) w_ifid_nxt = IFID_BUBBLE;
    end
  end

  // Outputs decoded from the state register
  always_comb begin
    imemREN      = 1'b0;
    fetch_halted = 1'b0;
    imemaddr     = r_pc;
    case (r_state)
      S_FETCH:  imemREN      = 1'b1;
      S_HALTED: fetch_halted = 1'b1;
      default:  imemREN      = 1'b0;
    endcase
  end

  assign id_instr = r_ifid.instr;
  assign id_pc    = r_ifid.pc;
  assign id_npc   = r_ifid.npc;
  assign id_valid = r_ifid.valid;

`ifdef IFETCH_PERF_EN
  logic [XLEN-1:0] r_fetch_count;
  logic [XLEN-1:0] r_stall_count;
  logic            w_load_valid;
  logic            w_stall_tick;

  // A valid word enters IF/ID only on an unpreempted advance
  assign w_load_valid = (r_state != S_HALTED) && !halt && !redirect_valid && !if_id_flush &&
                        w_advance && ((r_state == S_HOLD) || ihit);
  assign w_stall_tick = (r_state == S_HOLD) || ((r_state == S_FETCH) && !ihit);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_load_valid) r_fetch_count <= r_fetch_count + XLEN'(1);
      if (w_stall_tick) r_stall_count <= r_stall_count + XLEN'(1);
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a behavioural fetch model.
module tb_fetch_unit;

  localparam logic [31:0] PC_INIT = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        pcen, if_id_en, if_id_flush, redirect_valid, halt, ihit;
  logic [31:0] redirect_pc, imemload;
  logic        imemREN, id_valid, fetch_halted;
  logic [31:0] imemaddr, id_instr, id_pc, id_npc;
`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_count, stall_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(.PC_INIT(PC_INIT)) dut (
    .CLK(CLK), .nRST(nRST), .pcen(pcen), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload),
    .id_instr(id_instr), .id_pc(id_pc), .id_npc(id_npc), .id_valid(id_valid),
    .fetch_halted(fetch_halted)
`ifdef IFETCH_PERF_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  always #5 CLK = ~CLK;

  // Behavioural model: a fetcher that is either halted, holding one pending word, or free
  bit          m_halted, m_pend;
  logic [31:0] m_pc, m_word, m_fc, m_sc;
  logic [31:0] e_instr, e_pc, e_npc;
  bit          e_valid;

  function automatic void bubble();
    e_instr = '0; e_pc = '0; e_npc = '0; e_valid = 1'b0;
  endfunction

  function automatic void model_reset();
    m_halted = 1'b0; m_pend = 1'b0; m_pc = PC_INIT; m_word = '0;
    m_fc = '0; m_sc = '0;
    bubble();
  endfunction

  function automatic void deliver(input logic [31:0] word);
    e_instr = word; e_pc = m_pc; e_npc = m_pc + 32'd4; e_valid = 1'b1;
    m_pc = m_pc + 32'd4;
  endfunction

  function automatic void model_step();
    bit adv;
    bit delivered;
    adv = pcen && if_id_en;
    delivered = 1'b0;
    if (!m_halted && (m_pend || !ihit)) m_sc = m_sc + 32'd1;
    if (m_halted) begin
      if (if_id_flush) bubble();
      return;
    end
    if (halt) begin
      m_halted = 1'b1; m_pend = 1'b0; bubble();
      return;
    end
    if (redirect_valid) begin
      m_pc = redirect_pc & 32'hFFFF_FFFC; m_pend = 1'b0; bubble();
      return;
    end
    if (m_pend) begin
      if (adv) begin deliver(m_word); m_pend = 1'b0; delivered = 1'b1; end
    end else if (ihit) begin
      if (adv) begin deliver(imemload); delivered = 1'b1; end
      else begin m_word = imemload; m_pend = 1'b1; end
    end else if (if_id_en) begin
      bubble();
    end
    if (if_id_flush) bubble();
    else if (delivered) m_fc = m_fc + 32'd1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("imemREN",      32'(imemREN),      32'(!m_halted && !m_pend));
    chk("imemaddr",     imemaddr,          m_pc);
    chk("id_instr",     id_instr,          e_instr);
    chk("id_pc",        id_pc,             e_pc);
    chk("id_npc",       id_npc,            e_npc);
    chk("id_valid",     32'(id_valid),     32'(e_valid));
    chk("fetch_halted", 32'(fetch_halted), 32'(m_halted));
`ifdef IFETCH_PERF_EN
    chk("fetch_count",  fetch_count,       m_fc);
    chk("stall_count",  stall_count,       m_sc);
`endif
  endtask

  task automatic set_in(input bit hit, input bit pc_en, input bit ifid_en, input bit flush,
                        input bit rv, input logic [31:0] rpc, input bit hlt);
    ihit = hit; pcen = pc_en; if_id_en = ifid_en; if_id_flush = flush;
    redirect_valid = rv; redirect_pc = rpc; halt = hlt; imemload = $urandom();
  endtask

  task automatic cyc();
    model_step();
    @(posedge CLK);
    #1;
    check_model();
  endtask

  logic [31:0] held, skid, word;

  initial begin
    set_in(0, 0, 0, 0, 0, 32'h0, 0);
    #1 nRST = 1'b0;
    model_reset();
    #11;
    check_model();
    chk("reset_addr", imemaddr, PC_INIT);
    chk("reset_ren", 32'(imemREN), 32'd1);
    @(negedge CLK);
    nRST = 1'b1;

    // Straight-line fetch with every cycle hitting
    for (int k = 0; k < 4; k++) begin
      set_in(1, 1, 1, 0, 0, 32'h0, 0);
      cyc();
      chk("seq_addr", imemaddr, 32'(4 * (k + 1)));
      chk("seq_id_pc", id_pc, 32'(4 * k));
      chk("seq_id_npc", id_npc, 32'(4 * k + 4));
      chk("seq_valid", 32'(id_valid), 32'd1);
    end

    // Load-use stall at pc 0x10
    set_in(1, 0, 0, 0, 0, 32'h0, 0);
    held = imemload;
    cyc();
    chk("hold_ren", 32'(imemREN), 32'd0);
    chk("hold_addr", imemaddr, 32'h10);
    set_in(1, 0, 0, 0, 0, 32'h0, 0);
    cyc();
    chk("hold2_ren", 32'(imemREN), 32'd0);
    chk("hold2_addr", imemaddr, 32'h10);
    set_in(1, 1, 1, 0, 0, 32'h0, 0);
    cyc();
    chk("release_instr", id_instr, held);
    chk("release_id_pc", id_pc, 32'h10);
    chk("release_addr", imemaddr, 32'h14);

    // Redirect while holding a skid word
    set_in(1, 0, 0, 0, 0, 32'h0, 0);
    skid = imemload;
    cyc();
    chk("redir_pre_ren", 32'(imemREN), 32'd0);
    set_in(1, 1, 1, 0, 1, 32'h203, 0);
    cyc();
    chk("redir_addr", imemaddr, 32'h200);
    chk("redir_valid", 32'(id_valid), 32'd0);
    chk("redir_ren", 32'(imemREN), 32'd1);
    set_in(1, 1, 1, 0, 0, 32'h0, 0);
    if (imemload == skid) imemload = ~skid;
    word = imemload;
    cyc();
    chk("redir_instr", id_instr, word);
    chk("redir_id_pc", id_pc, 32'h200);

    // PC wrap at top of address space
    set_in(0, 1, 1, 0, 1, 32'hFFFF_FFFC, 0);
    cyc();
    chk("wrap_pre_addr", imemaddr, 32'hFFFF_FFFC);
    set_in(1, 1, 1, 0, 0, 32'h0, 0);
    cyc();
    chk("wrap_addr", imemaddr, 32'h0000_0000);
    chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap_id_npc", id_npc, 32'h0000_0000);

    // Randomized traffic (no halt)
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 85,
             $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 5, $urandom(), 0);
      cyc();
    end

    // Asynchronous reset while holding
    set_in(1, 0, 0, 0, 0, 32'h0, 0);
    cyc();
    chk("pre_rst_ren", 32'(imemREN), 32'd0);
    #2 nRST = 1'b0;
    model_reset();
    #1;
    check_model();
    chk("rst_addr", imemaddr, PC_INIT);
    chk("rst_ren", 32'(imemREN), 32'd1);
    chk("rst_valid", 32'(id_valid), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_in(1, 1, 1, 0, 0, 32'h0, 0);
      cyc();
    end

    // Halt together with redirect: halt wins, pc frozen at 0xC
    set_in(1, 1, 1, 0, 1, 32'h400, 1);
    cyc();
    chk("halt_flag", 32'(fetch_halted), 32'd1);
    chk("halt_ren", 32'(imemREN), 32'd0);
    chk("halt_pc", imemaddr, 32'hC);
    chk("halt_valid", 32'(id_valid), 32'd0);
    for (int i = 0; i < 20; i++) begin
      set_in($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom(), $urandom_range(0, 1));
      cyc();
      chk("halted_pc", imemaddr, 32'hC);
      chk("halted_ren", 32'(imemREN), 32'd0);
    end

    // Only reset leaves HALTED
    #2 nRST = 1'b0;
    model_reset();
    #1;
    check_model();
    chk("unhalt_flag", 32'(fetch_halted), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
